// File: rtl/cr_kme_int_responder_pkg.sv
// Shared KME interrupt constants and the responder state type.
package cr_kmePKG;

  localparam logic [10:0] KME_INT_STATUS_ADDR = 11'h37C;
  localparam int          KME_INT_NUM_SRC     = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_WR_REQ  = 2'd2,
    ST_HOLDOFF = 2'd3
  } kme_int_state_e;

endpackage

// File: rtl/cr_kme_int_sat_cnt.sv
// Saturating event counter; clr wins over inc in the same cycle.
module cr_kme_int_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_i && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cr_kme_int_responder.sv
// Autonomous KME interrupt service agent: read status, W1C the allowed bits, hold off.
// Per-source statistics are built only when CR_KME_INT_RESP_STATS_EN is defined.
module cr_kme_int_responder
  import cr_kmePKG::*;
#(
  parameter logic [10:0] STATUS_ADDR = KME_INT_STATUS_ADDR,
  parameter int          N_SRC       = KME_INT_NUM_SRC,
  parameter int          CNT_W       = 16,
  parameter int          HOLDOFF_CYC = 4,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_SRC-1:0]       clear_mask,
  input  logic                   kme_interrupt,
  output logic                   reg_req,
  output logic                   reg_wr,
  output logic [10:0]            reg_addr,
  output logic [31:0]            reg_wdata,
  input  logic                   reg_ack,
  input  logic [31:0]            reg_rdata,
  output logic                   busy,
  output logic [N_SRC-1:0]       last_status,
  output logic [N_SRC*CNT_W-1:0] src_count,
  output logic [CNT_W-1:0]       spurious_count,
  input  logic                   count_clr,
  output logic                   timeout_err,
  output logic                   service_done
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  kme_int_state_e    state_q, state_d;
  logic              req_q, req_d, wr_q, wr_d;
  logic [10:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_SRC-1:0]  last_q, last_d;
  logic              terr_q, terr_d;

  logic             start, acc, rd_ack, tmo, hold_last;
  logic [N_SRC-1:0] status, mask;

  // An ack only counts while a request is actually outstanding.
  assign start     = enable && kme_interrupt;
  assign acc       = req_q && reg_ack;
  assign rd_ack    = acc && (state_q == ST_RD_REQ);
  assign tmo       = req_q && !reg_ack && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
  assign hold_last = (hold_q == HOLD_W'(HOLDOFF_CYC - 1));
  assign status    = reg_rdata[N_SRC-1:0];
  assign mask      = status & clear_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_RD_REQ;
      ST_RD_REQ:  if (acc)   state_d = (mask != '0) ? ST_WR_REQ : ST_HOLDOFF;
                  else if (tmo) state_d = ST_HOLDOFF;
      ST_WR_REQ:  if (acc || tmo) state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE: if (start) begin
        req_d   = 1'b1;
        wr_d    = 1'b0;
        addr_d  = STATUS_ADDR;
        wdata_d = '0;
      end
      ST_RD_REQ: if (acc) begin
        last_d = status;
        if (mask != '0) begin
          wr_d               = 1'b1;
          wdata_d            = '0;
          wdata_d[N_SRC-1:0] = mask;
        end else begin
          req_d = 1'b0;
        end
      end else if (tmo) begin
        req_d = 1'b0;
      end
      ST_WR_REQ: if (acc || tmo) begin
        req_d = 1'b0;
        wr_d  = 1'b0;
      end
      default: ;
    endcase
    if (count_clr) terr_d = 1'b0;
    else if (tmo)  terr_d = 1'b1;
    wait_d = (req_q && !acc && !tmo) ? wait_q + 1'b1 : '0;
    hold_d = (state_q == ST_HOLDOFF && !hold_last) ? hold_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      last_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  assign reg_req      = req_q;
  assign reg_wr       = wr_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign last_status  = last_q;
  assign timeout_err  = terr_q;
  assign busy         = (state_q != ST_IDLE);
  assign service_done = (state_q == ST_HOLDOFF) && hold_last;

`ifdef CR_KME_INT_RESP_STATS_EN
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    cr_kme_int_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (rd_ack && status[i]),
      .clr_i (count_clr),
      .cnt_o (src_count[i*CNT_W +: CNT_W])
    );
  end
  cr_kme_int_sat_cnt #(.CNT_W(CNT_W)) u_spur (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rd_ack && (status == '0)),
    .clr_i (count_clr),
    .cnt_o (spurious_count)
  );
`else
  assign src_count      = '0;
  assign spurious_count = '0;
  logic unused_rd_ack;
  assign unused_rd_ack  = rd_ack;
`endif

  logic unused_rdata;
  assign unused_rdata = ^reg_rdata[31:N_SRC];

endmodule

// File: tb/tb_cr_kme_int_responder.sv
// Directed bench for cr_kme_int_responder with a hand-driven register-bus responder.
module tb_cr_kme_int_responder;

  localparam int N = 5;
  localparam int W = 16;
`ifdef CR_KME_INT_RESP_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] clear_mask = '0;
  logic         kme_interrupt = 1'b0;
  logic         reg_req, reg_wr;
  logic [10:0]  reg_addr;
  logic [31:0]  reg_wdata;
  logic         reg_ack = 1'b0;
  logic [31:0]  reg_rdata = '0;
  logic         busy;
  logic [N-1:0] last_status;
  logic [N*W-1:0] src_count;
  logic [W-1:0] spurious_count;
  logic         count_clr = 1'b0;
  logic         timeout_err, service_done;

  logic         sat_inc = 1'b0, sat_clr = 1'b0;
  logic [1:0]   sat_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cr_kme_int_responder dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear_mask(clear_mask),
    .kme_interrupt(kme_interrupt), .reg_req(reg_req), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack),
    .reg_rdata(reg_rdata), .busy(busy), .last_status(last_status),
    .src_count(src_count), .spurious_count(spurious_count),
    .count_clr(count_clr), .timeout_err(timeout_err), .service_done(service_done)
  );

  cr_kme_int_sat_cnt #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .inc_i(sat_inc), .clr_i(sat_clr), .cnt_o(sat_cnt)
  );

  function automatic int src(input int i);
    return int'(src_count[i*W +: W]);
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (reg_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int i = 0; i < 40; i++) begin
      if (service_done) begin k = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack_once(input logic [31:0] d);
    reg_ack = 1'b1; reg_rdata = d;
    @(negedge clk);
    reg_ack = 1'b0; reg_rdata = '0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({reg_req, reg_wr, busy, timeout_err, service_done, reg_addr, reg_wdata, last_status} !== '0) begin
      n_err++; $display("FAIL reset_outputs: req=%b wr=%b busy=%b addr=%h wdata=%h last=%h",
                        reg_req, reg_wr, busy, reg_addr, reg_wdata, last_status);
    end
    n_vec++;
    if (src_count !== '0 || spurious_count !== '0) begin
      n_err++; $display("FAIL reset_counters: src=%h spur=%h want 0", src_count, spurious_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok; int k;
    enable = 1'b1; clear_mask = 5'h1F; kme_interrupt = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({reg_req, reg_wr, reg_addr} !== {1'b1, 1'b0, 11'h37C}) begin
      n_err++; $display("FAIL basic_read_req: req=%b wr=%b addr=%h want 1 0 37c", reg_req, reg_wr, reg_addr);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({reg_req, reg_wr, reg_addr} !== {1'b1, 1'b0, 11'h37C}) begin
      n_err++; $display("FAIL basic_read_hold: req=%b wr=%b addr=%h", reg_req, reg_wr, reg_addr);
    end
    ack_once(32'h0000_0005);
    kme_interrupt = 1'b0;
    n_vec++;
    if ({reg_req, reg_wr, reg_addr, reg_wdata} !== {1'b1, 1'b1, 11'h37C, 32'h5}) begin
      n_err++; $display("FAIL basic_write: req=%b wr=%b addr=%h wdata=%h want 1 1 37c 5",
                        reg_req, reg_wr, reg_addr, reg_wdata);
    end
    n_vec++;
    if (last_status !== 5'h05) begin
      n_err++; $display("FAIL basic_last_status: got %h want 05", last_status);
    end
    ack_once(32'h0);
    n_vec++;
    if (reg_req !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_holdoff_entry: req=%b busy=%b want 0 1", reg_req, busy);
    end
    wait_done(k);
    n_vec++;
    if (k != 3) begin
      n_err++; $display("FAIL basic_holdoff_len: done after %0d cycles want 3", k);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || service_done !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, service_done);
    end
    n_vec++;
    if (src(0) != ST || src(1) != 0 || src(2) != ST || int'(spurious_count) != 0) begin
      n_err++; $display("FAIL basic_counts: s0=%0d s1=%0d s2=%0d spur=%0d want %0d 0 %0d 0",
                        src(0), src(1), src(2), spurious_count, ST, ST);
    end
    wait_req(ok);
    n_vec++;
    if (ok) begin n_err++; $display("FAIL basic_no_restart: req=1 want 0"); end
  endtask

  task automatic test_masked;
    bit ok; int k;
    clear_mask = 5'h1D; kme_interrupt = 1'b1;
    wait_req(ok);
    kme_interrupt = 1'b0;
    ack_once(32'h0000_0002);
    n_vec++;
    if (!ok || reg_req !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL masked_no_write: ok=%b req=%b busy=%b want 1 0 1", ok, reg_req, busy);
    end
    n_vec++;
    if (last_status !== 5'h02 || src(1) != ST || int'(spurious_count) != 0) begin
      n_err++; $display("FAIL masked_counts: last=%h s1=%0d spur=%0d want 02 %0d 0",
                        last_status, src(1), spurious_count, ST);
    end
    wait_done(k);
    @(negedge clk);
  endtask

  task automatic test_spurious;
    bit ok; int k;
    clear_mask = 5'h1F; kme_interrupt = 1'b1;
    wait_req(ok);
    kme_interrupt = 1'b0;
    ack_once(32'h0);
    n_vec++;
    if (!ok || reg_req !== 1'b0 || last_status !== 5'h00) begin
      n_err++; $display("FAIL spurious_no_write: ok=%b req=%b last=%h", ok, reg_req, last_status);
    end
    n_vec++;
    if (int'(spurious_count) != ST) begin
      n_err++; $display("FAIL spurious_count: got %0d want %0d", spurious_count, ST);
    end
    wait_done(k);
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok; int k; int cnt;
    kme_interrupt = 1'b1;
    wait_req(ok);
    kme_interrupt = 1'b0;
    cnt = 0;
    while (reg_req && cnt < 400) begin cnt++; @(negedge clk); end
    n_vec++;
    if (cnt != 255) begin
      n_err++; $display("FAIL timeout_len: req high %0d cycles want 255", cnt);
    end
    n_vec++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL timeout_flag: err=%b busy=%b want 1 1", timeout_err, busy);
    end
    n_vec++;
    if (src(0) != ST || src(1) != ST || src(2) != ST || src(3) != 0 || int'(spurious_count) != ST) begin
      n_err++; $display("FAIL timeout_counts_kept: s0=%0d s1=%0d s2=%0d s3=%0d spur=%0d",
                        src(0), src(1), src(2), src(3), spurious_count);
    end
    wait_done(k);
    @(negedge clk);
    n_vec++;
    if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: err=%b want 1", timeout_err); end
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    n_vec++;
    if (timeout_err !== 1'b0 || src_count !== '0 || spurious_count !== '0) begin
      n_err++; $display("FAIL count_clr: err=%b src=%h spur=%h want 0", timeout_err, src_count, spurious_count);
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int k;
    clear_mask = 5'h1F; kme_interrupt = 1'b1;
    wait_req(ok);
    ack_once(32'h0000_0010);
    n_vec++;
    if (!ok || {reg_req, reg_wr, reg_wdata} !== {1'b1, 1'b1, 32'h10}) begin
      n_err++; $display("FAIL b2b_write1: req=%b wr=%b wdata=%h want 1 1 10", reg_req, reg_wr, reg_wdata);
    end
    ack_once(32'h0);
    wait_done(k);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || reg_req !== 1'b0) begin
      n_err++; $display("FAIL b2b_gap: busy=%b req=%b want 0 0", busy, reg_req);
    end
    @(negedge clk);
    n_vec++;
    if ({reg_req, reg_wr} !== 2'b10) begin
      n_err++; $display("FAIL b2b_restart: req=%b wr=%b want 1 0", reg_req, reg_wr);
    end
    ack_once(32'h0000_0010);
    kme_interrupt = 1'b0;
    ack_once(32'h0);
    wait_done(k);
    @(negedge clk);
    n_vec++;
    if (src(4) != 2 * ST || k != 3) begin
      n_err++; $display("FAIL b2b_count: s4=%0d hold=%0d want %0d 3", src(4), k, 2 * ST);
    end
  endtask

  task automatic test_reset_mid_write;
    bit ok; int seen;
    kme_interrupt = 1'b1;
    wait_req(ok);
    kme_interrupt = 1'b0;
    ack_once(32'h0000_0001);
    n_vec++;
    if ({reg_req, reg_wr} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_write_pending: req=%b wr=%b want 1 1", reg_req, reg_wr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({reg_req, reg_wr, busy, timeout_err, reg_addr, reg_wdata, last_status} !== '0 ||
        src_count !== '0 || spurious_count !== '0) begin
      n_err++; $display("FAIL rstmid_async: req=%b wr=%b busy=%b last=%h src=%h spur=%h",
                        reg_req, reg_wr, busy, last_status, src_count, spurious_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reg_ack = 1'b1; reg_rdata = 32'h1F;
    @(negedge clk);
    reg_ack = 1'b0; reg_rdata = '0;
    seen = 0;
    repeat (5) begin if (reg_req) seen++; @(negedge clk); end
    n_vec++;
    if (seen != 0 || last_status !== 5'h00 || src_count !== '0) begin
      n_err++; $display("FAIL rstmid_no_reissue: req_cycles=%0d last=%h src=%h want 0", seen, last_status, src_count);
    end
  endtask

  task automatic test_saturation;
    sat_inc = 1'b1;
    repeat (5) @(negedge clk);
    sat_inc = 1'b0;
    n_vec++;
    if (sat_cnt !== 2'd3) begin n_err++; $display("FAIL sat_5_events: got %0d want 3", sat_cnt); end
    sat_inc = 1'b1; sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    n_vec++;
    if (sat_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clr_wins: got %0d want 0", sat_cnt); end
    @(negedge clk);
    sat_inc = 1'b0;
    n_vec++;
    if (sat_cnt !== 2'd1) begin n_err++; $display("FAIL sat_after_clr: got %0d want 1", sat_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_masked;
    test_spurious;
    test_timeout;
    test_back_to_back;
    test_reset_mid_write;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
